reg_file_rd_server: RTL and testbench

//   Register file, NUM_REGS x DATA_W, with one write port and one handshaked read port.
//   The read side takes address requests (valid/ready) and returns data responses (valid/ready).
//   A 2-entry response buffer decouples reads from a stalled consumer.
//   The block is the read-side companion to the enable-gated 32-bit register: those registers are written here, and this block serves their contents back out.

---
 rtl/reg_file_pkg.sv | 20 ++
 rtl/reg_file_rd_server_if.sv | 34 +++
 rtl/reg_rd_rsp_fifo2.sv | 60 ++++++
 rtl/reg_file_rd_server.sv | 73 +++++++
 tb/tb_reg_file_rd_server.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/reg_file_pkg.sv
`default_nettype none
// ============================================================================
// Module   : reg_file_pkg
// Brief    : Shared widths, response record and buffer depth for the
//            register-file read server.
// Revision : 1.0 - initial release
// ============================================================================
package reg_file_pkg;

    localparam int DEFAULT_DATA_W = 32;
    localparam int DEFAULT_ADDR_W = 3;
    localparam int RSP_DEPTH      = 2;

    typedef struct packed {
        logic [DEFAULT_ADDR_W-1:0] addr;
        logic [DEFAULT_DATA_W-1:0] data;
    } rsp_t;

endpackage : reg_file_pkg
`default_nettype wire

// File: rtl/reg_file_rd_server_if.sv
`default_nettype none
// ============================================================================
// Module   : reg_file_rd_server_if
// Brief    : Write port plus handshaked read request/response bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface reg_file_rd_server_if
    import reg_file_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int ADDR_W = DEFAULT_ADDR_W
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              rd_req_valid;
    logic              rd_req_ready;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_rsp_valid;
    logic              rd_rsp_ready;
    logic [DATA_W-1:0] rd_rsp_data;
    logic [ADDR_W-1:0] rd_rsp_addr;

    modport master (
        output wr_en, wr_addr, wr_data, rd_req_valid, rd_addr, rd_rsp_ready,
        input  rd_req_ready, rd_rsp_valid, rd_rsp_data, rd_rsp_addr
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_req_valid, rd_addr, rd_rsp_ready,
        output rd_req_ready, rd_rsp_valid, rd_rsp_data, rd_rsp_addr
    );
endinterface : reg_file_rd_server_if
`default_nettype wire

// File: rtl/reg_rd_rsp_fifo2.sv
`default_nettype none
// ============================================================================
// Module   : reg_rd_rsp_fifo2
// Brief    : Two-entry response FIFO; owns the occupancy state and pointers.
// Revision : 1.0 - initial release
// ============================================================================
module reg_rd_rsp_fifo2
    import reg_file_pkg::*;
(
    input  wire logic       clk,
    input  wire logic       reset,
    input  wire logic       push,
    input  wire rsp_t       push_data,
    input  wire logic       pop,
    output logic [1:0]      count,
    output rsp_t            head
);
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    logic [1:0] r_state;
    logic       r_wr_ptr;
    logic       r_rd_ptr;
    rsp_t       r_mem [RSP_DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_EMPTY;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            for (int i = 0; i < RSP_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            // When full, a same-edge push overwrites the slot being popped.
            if (push) begin
                r_mem[r_wr_ptr] <= push_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case (r_state)
                ST_EMPTY: if (push)              r_state <= ST_ONE;
                ST_ONE: begin
                    if (push && !pop)            r_state <= ST_TWO;
                    else if (pop && !push)       r_state <= ST_EMPTY;
                end
                ST_TWO:   if (pop && !push)      r_state <= ST_ONE;
                default:                         r_state <= ST_EMPTY;
            endcase
        end
    end

    assign count = r_state;
    assign head  = r_mem[r_rd_ptr];

endmodule : reg_rd_rsp_fifo2
`default_nettype wire

// File: rtl/reg_file_rd_server.sv
`default_nettype none
// ============================================================================
// Module   : reg_file_rd_server
// Brief    : NUM_REGS x DATA_W register file with one write port and a
//            handshaked read port backed by a 2-entry response buffer.
//            Define READ_BYPASS_EN for write-first same-address collisions.
// Revision : 1.0 - initial release
// ============================================================================
module reg_file_rd_server
    import reg_file_pkg::*;
#(
    parameter int DATA_W   = DEFAULT_DATA_W,
    parameter int ADDR_W   = DEFAULT_ADDR_W,
    parameter int NUM_REGS = 8
)(
    input  wire logic             clk,
    input  wire logic             reset,
    reg_file_rd_server_if.slave   bus
);
    if ((NUM_REGS != (1 << ADDR_W)) || (DATA_W != DEFAULT_DATA_W) ||
        (ADDR_W != DEFAULT_ADDR_W)) begin : g_param_check
        $error("reg_file_rd_server: unsupported DATA_W/ADDR_W/NUM_REGS");
    end

    logic [DATA_W-1:0] r_regs [NUM_REGS];
    logic [DATA_W-1:0] w_rd_data;
    logic [1:0]        w_count;
    logic              w_push;
    logic              w_pop;
    rsp_t              w_push_data;
    rsp_t              w_head;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (bus.wr_en) begin
            r_regs[bus.wr_addr] <= bus.wr_data;
        end
    end

`ifdef READ_BYPASS_EN
    assign w_rd_data = (bus.wr_en && (bus.wr_addr == bus.rd_addr)) ?
                       bus.wr_data : r_regs[bus.rd_addr];
`else
    assign w_rd_data = r_regs[bus.rd_addr];
`endif

    // Ready looks through to the consumer so a full buffer can push and pop together.
    assign bus.rd_req_ready = (w_count != 2'd2) | bus.rd_rsp_ready;
    assign bus.rd_rsp_valid = (w_count != 2'd0);

    assign w_push           = bus.rd_req_valid & bus.rd_req_ready;
    assign w_pop            = bus.rd_rsp_valid & bus.rd_rsp_ready;
    assign w_push_data.addr = bus.rd_addr;
    assign w_push_data.data = w_rd_data;

    reg_rd_rsp_fifo2 u_rsp_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (w_push),
        .push_data (w_push_data),
        .pop       (w_pop),
        .count     (w_count),
        .head      (w_head)
    );

    assign bus.rd_rsp_data = w_head.data;
    assign bus.rd_rsp_addr = w_head.addr;

endmodule : reg_file_rd_server
`default_nettype wire

// File: tb/tb_reg_file_rd_server.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_file_rd_server
// Brief    : Directed self-checking bench for reg_file_rd_server.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_file_rd_server;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_fail;

    reg_file_rd_server_if bus ();

    reg_file_rd_server dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.wr_en        = 1'b0;
        bus.wr_addr      = '0;
        bus.wr_data      = '0;
        bus.rd_req_valid = 1'b0;
        bus.rd_addr      = '0;
    endtask

    task automatic write_reg(input logic [2:0] a, input logic [31:0] d);
        bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d;
        tick();
        bus.wr_en = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        bus.rd_rsp_ready = 1'b1;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_cmp++; if (bus.rd_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", bus.rd_rsp_valid); end
        n_cmp++; if (bus.rd_rsp_data !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h expected 00000000", bus.rd_rsp_data); end
        n_cmp++; if (bus.rd_rsp_addr !== 3'd0) begin n_fail++; $display("FAIL reset_addr: got %0d expected 0", bus.rd_rsp_addr); end
        n_cmp++; if (bus.rd_req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %b expected 1", bus.rd_req_ready); end
        bus.rd_req_valid = 1'b1; bus.rd_addr = 3'd3;
        tick();
        bus.rd_req_valid = 1'b0;
        n_cmp++; if (bus.rd_rsp_valid !== 1'b1) begin n_fail++; $display("FAIL rd3_valid: got %b expected 1", bus.rd_rsp_valid); end
        n_cmp++; if (bus.rd_rsp_data !== 32'h0) begin n_fail++; $display("FAIL rd3_data: got %h expected 00000000", bus.rd_rsp_data); end
        n_cmp++; if (bus.rd_rsp_addr !== 3'd3) begin n_fail++; $display("FAIL rd3_addr: got %0d expected 3", bus.rd_rsp_addr); end
        tick();
        n_cmp++; if (bus.rd_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rd3_popped: got %b expected 0", bus.rd_rsp_valid); end
    endtask

    task automatic test_write_read();
        write_reg(3'd5, 32'haabbccdd);
        bus.rd_req_valid = 1'b1; bus.rd_addr = 3'd5;
        tick();
        bus.rd_req_valid = 1'b0;
        n_cmp++; if (bus.rd_rsp_valid !== 1'b1) begin n_fail++; $display("FAIL wr_rd_valid: got %b expected 1", bus.rd_rsp_valid); end
        n_cmp++; if (bus.rd_rsp_data !== 32'haabbccdd) begin n_fail++; $display("FAIL wr_rd_data: got %h expected aabbccdd", bus.rd_rsp_data); end
        n_cmp++; if (bus.rd_rsp_addr !== 3'd5) begin n_fail++; $display("FAIL wr_rd_addr: got %0d expected 5", bus.rd_rsp_addr); end
        tick();
    endtask

    task automatic test_back_pressure();
        write_reg(3'd1, 32'h11111111);
        write_reg(3'd2, 32'h22222222);
        write_reg(3'd4, 32'h44444444);
        bus.rd_rsp_ready = 1'b0;
        bus.rd_req_valid = 1'b1; bus.rd_addr = 3'd1; #1;
        n_cmp++; if (bus.rd_req_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_0: got %b expected 1", bus.rd_req_ready); end
        tick();
        bus.rd_addr = 3'd2; #1;
        n_cmp++; if (bus.rd_req_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_1: got %b expected 1", bus.rd_req_ready); end
        tick();
        bus.rd_addr = 3'd4; #1;
        n_cmp++; if (bus.rd_req_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_full: got %b expected 0", bus.rd_req_ready); end
        tick();
        n_cmp++; if (bus.rd_req_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_held: got %b expected 0", bus.rd_req_ready); end
        n_cmp++; if (bus.rd_rsp_addr !== 3'd1 || bus.rd_rsp_data !== 32'h11111111) begin n_fail++; $display("FAIL bp_head_hold: got %0d/%h expected 1/11111111", bus.rd_rsp_addr, bus.rd_rsp_data); end
        bus.rd_rsp_ready = 1'b1; #1;
        n_cmp++; if (bus.rd_req_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_passthru: got %b expected 1", bus.rd_req_ready); end
        tick();
        bus.rd_req_valid = 1'b0;
        n_cmp++; if (bus.rd_rsp_addr !== 3'd2 || bus.rd_rsp_data !== 32'h22222222) begin n_fail++; $display("FAIL bp_second: got %0d/%h expected 2/22222222", bus.rd_rsp_addr, bus.rd_rsp_data); end
        tick();
        n_cmp++; if (bus.rd_rsp_valid !== 1'b1 || bus.rd_rsp_addr !== 3'd4 || bus.rd_rsp_data !== 32'h44444444) begin n_fail++; $display("FAIL bp_third: got %b/%0d/%h expected 1/4/44444444", bus.rd_rsp_valid, bus.rd_rsp_addr, bus.rd_rsp_data); end
        tick();
        n_cmp++; if (bus.rd_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drained: got %b expected 0", bus.rd_rsp_valid); end
    endtask

    task automatic test_full_pop();
        write_reg(3'd6, 32'h99887766);
        bus.rd_rsp_ready = 1'b0;
        bus.rd_req_valid = 1'b1; bus.rd_addr = 3'd5;
        tick();
        bus.rd_addr = 3'd2;
        tick();
        bus.rd_addr = 3'd6;
        bus.rd_rsp_ready = 1'b1; #1;
        n_cmp++; if (bus.rd_req_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready: got %b expected 1", bus.rd_req_ready); end
        n_cmp++; if (bus.rd_rsp_addr !== 3'd5 || bus.rd_rsp_data !== 32'haabbccdd) begin n_fail++; $display("FAIL full_head0: got %0d/%h expected 5/aabbccdd", bus.rd_rsp_addr, bus.rd_rsp_data); end
        tick();
        bus.rd_req_valid = 1'b0;
        bus.rd_rsp_ready = 1'b0; #1;
        n_cmp++; if (bus.rd_req_ready !== 1'b0) begin n_fail++; $display("FAIL full_still_two: got %b expected 0", bus.rd_req_ready); end
        n_cmp++; if (bus.rd_rsp_addr !== 3'd2 || bus.rd_rsp_data !== 32'h22222222) begin n_fail++; $display("FAIL full_head1: got %0d/%h expected 2/22222222", bus.rd_rsp_addr, bus.rd_rsp_data); end
        bus.rd_rsp_ready = 1'b1;
        tick();
        n_cmp++; if (bus.rd_rsp_valid !== 1'b1 || bus.rd_rsp_addr !== 3'd6 || bus.rd_rsp_data !== 32'h99887766) begin n_fail++; $display("FAIL full_third: got %b/%0d/%h expected 1/6/99887766", bus.rd_rsp_valid, bus.rd_rsp_addr, bus.rd_rsp_data); end
        tick();
        n_cmp++; if (bus.rd_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL full_drained: got %b expected 0", bus.rd_rsp_valid); end
    endtask

    task automatic test_collision();
        logic [31:0] exp_data;
`ifdef READ_BYPASS_EN
        exp_data = 32'habcdef12;
`else
        exp_data = 32'h11223344;
`endif
        write_reg(3'd2, 32'h11223344);
        bus.rd_rsp_ready = 1'b1;
        bus.wr_en = 1'b1; bus.wr_addr = 3'd2; bus.wr_data = 32'habcdef12;
        bus.rd_req_valid = 1'b1; bus.rd_addr = 3'd2;
        tick();
        bus.wr_en = 1'b0;
        n_cmp++; if (bus.rd_rsp_data !== exp_data) begin n_fail++; $display("FAIL collision_data: got %h expected %h", bus.rd_rsp_data, exp_data); end
        tick();
        bus.rd_req_valid = 1'b0;
        n_cmp++; if (bus.rd_rsp_data !== 32'habcdef12) begin n_fail++; $display("FAIL collision_after: got %h expected abcdef12", bus.rd_rsp_data); end
        tick();
    endtask

    task automatic test_reset_mid();
        bus.rd_rsp_ready = 1'b0;
        bus.rd_req_valid = 1'b1; bus.rd_addr = 3'd5;
        tick();
        bus.rd_addr = 3'd6;
        tick();
        bus.wr_en = 1'b1; bus.wr_addr = 3'd7; bus.wr_data = 32'hffffffff;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        idle(); #1;
        n_cmp++; if (bus.rd_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL mid_reset_valid: got %b expected 0", bus.rd_rsp_valid); end
        n_cmp++; if (bus.rd_req_ready !== 1'b1) begin n_fail++; $display("FAIL mid_reset_ready: got %b expected 1", bus.rd_req_ready); end
        n_cmp++; if (bus.rd_rsp_data !== 32'h0 || bus.rd_rsp_addr !== 3'd0) begin n_fail++; $display("FAIL mid_reset_head: got %0d/%h expected 0/00000000", bus.rd_rsp_addr, bus.rd_rsp_data); end
        bus.rd_rsp_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.rd_req_valid = 1'b1; bus.rd_addr = 3'(i);
            tick();
            n_cmp++; if (bus.rd_rsp_data !== 32'h0 || bus.rd_rsp_addr !== 3'(i)) begin n_fail++; $display("FAIL mid_reset_reg%0d: got %0d/%h expected %0d/00000000", i, bus.rd_rsp_addr, bus.rd_rsp_data, i); end
        end
        bus.rd_req_valid = 1'b0;
        tick();
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        reset  = 1'b1;
        bus.rd_rsp_ready = 1'b0;
        idle();
        tick();
        test_reset();
        test_write_read();
        test_back_pressure();
        test_full_pop();
        test_collision();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_reg_file_rd_server
`default_nettype wire
